tcm_dport_arb: RTL and testbench



---
 rtl/tcm_dport_arb.sv | 124 ++++++++++++
 tb/tb_tcm_dport_arb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_dport_arb.sv
// tcm_dport_arb: shares the TCM data port between the CPU and an external requester.
// It routes in-order responses through an owner FIFO. TCM_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module tcm_dport_arb #(
  parameter int TAG_W       = 11,
  parameter int OUTST_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      cpu_addr_i,
  input  logic [31:0]      cpu_data_wr_i,
  input  logic             cpu_rd_i,
  input  logic [3:0]       cpu_wr_i,
  input  logic [TAG_W-1:0] cpu_req_tag_i,
  output logic             cpu_accept_o,
  output logic             cpu_ack_o,
  output logic [31:0]      cpu_data_rd_o,
  output logic [TAG_W-1:0] cpu_resp_tag_o,
  input  logic [31:0]      ext_addr_i,
  input  logic [31:0]      ext_data_wr_i,
  input  logic             ext_rd_i,
  input  logic [3:0]       ext_wr_i,
  output logic             ext_accept_o,
  output logic             ext_ack_o,
  output logic [31:0]      ext_data_rd_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_wr_o,
  output logic             mem_rd_o,
  output logic [3:0]       mem_wr_o,
  output logic [TAG_W-1:0] mem_req_tag_o,
  input  logic             mem_accept_i,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_data_rd_i,
  input  logic [TAG_W-1:0] mem_resp_tag_i,
  output logic             ack_err_o
);
  localparam int PW = $clog2(OUTST_DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(OUTST_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [OUTST_DEPTH-1:0] owner_q;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [PW:0]            count_q;
  logic                   ack_err_q;
  logic                   req_cpu, req_ext, fifo_full, fifo_empty;
  logic                   grant_cpu, grant_ext, issue, pop, head_ext;

  assign req_cpu    = cpu_rd_i | (|cpu_wr_i);
  assign req_ext    = ext_rd_i | (|ext_wr_i);
  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);

`ifdef TCM_ARB_ROUND_ROBIN_EN
  // prio_ext_q: the external side wins the next conflict.
  logic prio_ext_q;
  assign grant_cpu = !fifo_full & req_cpu & (!req_ext | !prio_ext_q);
  assign grant_ext = !fifo_full & req_ext & (!req_cpu | prio_ext_q);

  always_ff @(posedge clk_i) begin
    if (rst_i)      prio_ext_q <= 1'b0;
    else if (issue) prio_ext_q <= grant_cpu;
  end
`else
  assign grant_cpu = !fifo_full & req_cpu;
  assign grant_ext = !fifo_full & req_ext & !req_cpu;
`endif

  assign issue        = (grant_cpu | grant_ext) & mem_accept_i;
  assign cpu_accept_o = grant_cpu & mem_accept_i;
  assign ext_accept_o = grant_ext & mem_accept_i;

  always_comb begin
    mem_addr_o    = '0;
    mem_data_wr_o = '0;
    mem_rd_o      = 1'b0;
    mem_wr_o      = '0;
    mem_req_tag_o = '0;
    if (grant_cpu) begin
      mem_addr_o    = cpu_addr_i;
      mem_data_wr_o = cpu_data_wr_i;
      mem_rd_o      = cpu_rd_i;
      mem_wr_o      = cpu_wr_i;
      mem_req_tag_o = cpu_req_tag_i;
    end else if (grant_ext) begin
      mem_addr_o    = ext_addr_i;
      mem_data_wr_o = ext_data_wr_i;
      mem_rd_o      = ext_rd_i;
      mem_wr_o      = ext_wr_i;
    end
  end

  // Responses return in issue order, so the FIFO head names the owner.
  assign pop      = mem_ack_i & !fifo_empty;
  assign head_ext = owner_q[rd_ptr_q];

  assign cpu_ack_o      = pop & !head_ext;
  assign ext_ack_o      = pop & head_ext;
  assign cpu_data_rd_o  = cpu_ack_o ? mem_data_rd_i : '0;
  assign cpu_resp_tag_o = cpu_ack_o ? mem_resp_tag_i : '0;
  assign ext_data_rd_o  = ext_ack_o ? mem_data_rd_i : '0;
  assign ack_err_o      = ack_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ack_err_q <= 1'b0;
    end else begin
      if (issue) begin
        owner_q[wr_ptr_q] <= grant_ext;
        wr_ptr_q          <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({issue, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (mem_ack_i & fifo_empty) ack_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tcm_dport_arb.sv
// Bench for tcm_dport_arb: queue-based owner model checked every cycle, plus directed scenarios.
// Build with TCM_ARB_ROUND_ROBIN_EN defined to cover the round-robin variant.
module tb_tcm_dport_arb;
  localparam int TAG_W = 11;
  localparam int DEPTH = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [31:0]      cpu_addr_i, cpu_data_wr_i, ext_addr_i, ext_data_wr_i, mem_data_rd_i;
  logic             cpu_rd_i, ext_rd_i, mem_accept_i, mem_ack_i;
  logic [3:0]       cpu_wr_i, ext_wr_i;
  logic [TAG_W-1:0] cpu_req_tag_i, mem_resp_tag_i;
  logic             cpu_accept_o, cpu_ack_o, ext_accept_o, ext_ack_o, mem_rd_o, ack_err_o;
  logic [31:0]      cpu_data_rd_o, ext_data_rd_o, mem_addr_o, mem_data_wr_o;
  logic [TAG_W-1:0] cpu_resp_tag_o, mem_req_tag_o;
  logic [3:0]       mem_wr_o;

  always #5 clk_i = ~clk_i;

  tcm_dport_arb #(.TAG_W(TAG_W), .OUTST_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_wr_i(cpu_data_wr_i), .cpu_rd_i(cpu_rd_i),
    .cpu_wr_i(cpu_wr_i), .cpu_req_tag_i(cpu_req_tag_i), .cpu_accept_o(cpu_accept_o),
    .cpu_ack_o(cpu_ack_o), .cpu_data_rd_o(cpu_data_rd_o), .cpu_resp_tag_o(cpu_resp_tag_o),
    .ext_addr_i(ext_addr_i), .ext_data_wr_i(ext_data_wr_i), .ext_rd_i(ext_rd_i),
    .ext_wr_i(ext_wr_i), .ext_accept_o(ext_accept_o), .ext_ack_o(ext_ack_o),
    .ext_data_rd_o(ext_data_rd_o),
    .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .mem_req_tag_o(mem_req_tag_o), .mem_accept_i(mem_accept_i),
    .mem_ack_i(mem_ack_i), .mem_data_rd_i(mem_data_rd_i), .mem_resp_tag_i(mem_resp_tag_i),
    .ack_err_o(ack_err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: queue of outstanding owners (1 = ext), sticky error, RR preference.
  bit owner_m[$];
  bit err_m      = 1'b0;
  bit prio_ext_m = 1'b0;
  bit live       = 1'b0;

  // 0 = none, 1 = CPU, 2 = ext
  function automatic int exp_grant();
    bit rc, re;
    rc = cpu_rd_i | (|cpu_wr_i);
    re = ext_rd_i | (|ext_wr_i);
    if (owner_m.size() >= DEPTH) return 0;
    if (rc && re) begin
`ifdef TCM_ARB_ROUND_ROBIN_EN
      return prio_ext_m ? 2 : 1;
`else
      return 1;
`endif
    end
    if (rc) return 1;
    if (re) return 2;
    return 0;
  endfunction

  always @(posedge clk_i) begin : model_upd
    int g;
    if (rst_i) begin
      owner_m.delete();
      err_m      = 1'b0;
      prio_ext_m = 1'b0;
      live       = 1'b1;
    end else begin
      g = exp_grant();
      if (mem_ack_i) begin
        if (owner_m.size() == 0) err_m = 1'b1;
        else void'(owner_m.pop_front());
      end
      if (g != 0 && mem_accept_i) begin
        owner_m.push_back(g == 2);
        prio_ext_m = (g == 1);
      end
    end
  end

  always @(negedge clk_i) begin : monitor
    int g;
    bit pop, hd, ca, ea;
    if (live) begin
      g   = exp_grant();
      pop = mem_ack_i && owner_m.size() > 0;
      hd  = (owner_m.size() > 0) ? owner_m[0] : 1'b0;
      ca  = pop && !hd;
      ea  = pop && hd;
      chk("cpu_accept", cpu_accept_o, (g == 1) && mem_accept_i);
      chk("ext_accept", ext_accept_o, (g == 2) && mem_accept_i);
      chk("mem_addr", mem_addr_o, g == 1 ? cpu_addr_i : g == 2 ? ext_addr_i : 32'h0);
      chk("mem_wdata", mem_data_wr_o, g == 1 ? cpu_data_wr_i : g == 2 ? ext_data_wr_i : 32'h0);
      chk("mem_rd", mem_rd_o, g == 1 ? cpu_rd_i : g == 2 ? ext_rd_i : 1'b0);
      chk("mem_wr", mem_wr_o, g == 1 ? cpu_wr_i : g == 2 ? ext_wr_i : 4'h0);
      chk("mem_req_tag", mem_req_tag_o, g == 1 ? cpu_req_tag_i : '0);
      chk("cpu_ack", cpu_ack_o, ca);
      chk("ext_ack", ext_ack_o, ea);
      chk("cpu_rdata", cpu_data_rd_o, ca ? mem_data_rd_i : 32'h0);
      chk("cpu_resp_tag", cpu_resp_tag_o, ca ? mem_resp_tag_i : '0);
      chk("ext_rdata", ext_data_rd_o, ea ? mem_data_rd_i : 32'h0);
      chk("ack_err", ack_err_o, err_m);
    end
  end

  task automatic idle_inputs();
    cpu_addr_i = '0; cpu_data_wr_i = '0; cpu_rd_i = 1'b0; cpu_wr_i = '0; cpu_req_tag_i = '0;
    ext_addr_i = '0; ext_data_wr_i = '0; ext_rd_i = 1'b0; ext_wr_i = '0;
    mem_accept_i = 1'b0; mem_ack_i = 1'b0; mem_data_rd_i = '0; mem_resp_tag_i = '0;
  endtask

  task automatic settle();
    @(negedge clk_i); #1;
  endtask

  task automatic nxt();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    nxt();
    nxt();
    rst_i = 1'b0;
  endtask

  initial begin
    int seq [4];
    int exp_seq [4];
    rst_i = 1'b1;
    idle_inputs();
    do_reset();

    // 1: reset then idle
    settle();
    chk("t1_cpu_accept", cpu_accept_o, 0);
    chk("t1_cpu_ack", cpu_ack_o, 0);
    chk("t1_mem_addr", mem_addr_o, 0);
    chk("t1_ack_err", ack_err_o, 0);
    nxt();

    // 2: single CPU read, 1-cycle ack
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h100; cpu_req_tag_i = 11'h2A; mem_accept_i = 1'b1;
    settle();
    chk("t2_accept", cpu_accept_o, 1);
    chk("t2_mem_addr", mem_addr_o, 32'h100);
    chk("t2_mem_tag", mem_req_tag_o, 11'h2A);
    nxt();
    cpu_rd_i = 1'b0; mem_ack_i = 1'b1; mem_resp_tag_i = 11'h2A; mem_data_rd_i = 32'hDEADBEEF;
    settle();
    chk("t2_cpu_ack", cpu_ack_o, 1);
    chk("t2_resp_tag", cpu_resp_tag_o, 11'h2A);
    chk("t2_rdata", cpu_data_rd_o, 32'hDEADBEEF);
    chk("t2_ext_ack", ext_ack_o, 0);
    nxt();

    // 3: persistent conflict
    do_reset();
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h104; ext_wr_i = 4'hF; ext_addr_i = 32'h200;
    ext_data_wr_i = 32'hCAFE0001; mem_accept_i = 1'b1;
`ifdef TCM_ARB_ROUND_ROBIN_EN
    exp_seq = '{1, 2, 1, 2};
`else
    exp_seq = '{1, 1, 1, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      settle();
      seq[i] = cpu_accept_o ? 1 : ext_accept_o ? 2 : 0;
      chk($sformatf("t3_grant%0d", i), seq[i], exp_seq[i]);
      nxt();
    end
    idle_inputs();
    mem_ack_i = 1'b1; mem_data_rd_i = 32'h5555AAAA;
    repeat (4) nxt();

    // 4: back-to-back CPU reads with no acks
    do_reset();
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h400; mem_accept_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("t4_accept%0d", i), cpu_accept_o, (i < 4) ? 1 : 0);
      nxt();
    end
    mem_ack_i = 1'b1;
    settle();
    chk("t4_full_pop_accept", cpu_accept_o, 0);
    chk("t4_full_pop_ack", cpu_ack_o, 1);
    nxt();
    mem_ack_i = 1'b0;
    settle();
    chk("t4_freed_accept", cpu_accept_o, 1);
    nxt();
    idle_inputs();
    mem_ack_i = 1'b1;
    repeat (4) nxt();

    // 5: ext write then CPU read, in-order acks, push+pop overlap
    do_reset();
    ext_wr_i = 4'hF; ext_addr_i = 32'h300; ext_data_wr_i = 32'h0BADF00D; mem_accept_i = 1'b1;
    settle();
    chk("t5_ext_accept", ext_accept_o, 1);
    nxt();
    ext_wr_i = 4'h0; cpu_rd_i = 1'b1; cpu_addr_i = 32'h304; cpu_req_tag_i = 11'h11;
    mem_ack_i = 1'b1; mem_data_rd_i = 32'h0000A5A5;
    settle();
    chk("t5_cpu_accept", cpu_accept_o, 1);
    chk("t5_ext_ack", ext_ack_o, 1);
    chk("t5_ext_rdata", ext_data_rd_o, 32'h0000A5A5);
    chk("t5_cpu_ack_early", cpu_ack_o, 0);
    nxt();
    cpu_rd_i = 1'b0; mem_data_rd_i = 32'h12345678; mem_resp_tag_i = 11'h11;
    settle();
    chk("t5_cpu_ack", cpu_ack_o, 1);
    chk("t5_cpu_rdata", cpu_data_rd_o, 32'h12345678);
    chk("t5_ext_ack_late", ext_ack_o, 0);
    nxt();

    // 6: ack with empty FIFO (also proves the overlap left the count at one)
    settle();
    chk("t6_cpu_ack", cpu_ack_o, 0);
    chk("t6_ext_ack", ext_ack_o, 0);
    chk("t6_err_before", ack_err_o, 0);
    nxt();
    mem_ack_i = 1'b0;
    repeat (3) begin
      settle();
      chk("t6_err_sticky", ack_err_o, 1);
      nxt();
    end
    do_reset();
    settle();
    chk("t6_err_cleared", ack_err_o, 0);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
